// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: decoder/datapath signals exchanged with the multicycle control FSM
interface mips_multicycle_ctrl_if #(parameter int N = 32);
  logic [5:0] op;
  logic [5:0] funct;
  logic zero;
  logic mem_ready;
  logic [3:0] state;
  logic pc_we;
  logic [1:0] pc_src;
  logic ir_we;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic reg_we;
  logic reg_dst;
  logic mem_to_reg;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic ext_zero;
  logic [2:0] alu_ctl;
  logic illegal;
  logic [N-1:0] retired;
  modport master (
    input op, funct, zero, mem_ready,
    output state, pc_we, pc_src, ir_we, mem_req, mem_we, iord, reg_we, reg_dst,
    output mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctl, illegal, retired
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input state, pc_we, pc_src, ir_we, mem_req, mem_we, iord, reg_we, reg_dst,
    input mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctl, illegal, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with retired-instruction counter and opcode trap
module mips_multicycle_ctrl #(
  parameter int N = 32
) (
  input logic clk,
  input logic rstb,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [3:0] INIT      = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] R_EXEC    = 4'd3;
  localparam logic [3:0] R_WB      = 4'd4;
  localparam logic [3:0] MEM_ADDR  = 4'd5;
  localparam logic [3:0] MEM_READ  = 4'd6;
  localparam logic [3:0] MEM_WB    = 4'd7;
  localparam logic [3:0] MEM_WRITE = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] I_EXEC    = 4'd10;
  localparam logic [3:0] I_WB      = 4'd11;
  localparam logic [3:0] JUMP      = 4'd12;
  localparam logic [3:0] TRAP      = 4'd13;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  logic [3:0] st, nxt;
  logic [N-1:0] cnt;
  logic [2:0] r_ctl, i_ctl;
  logic r_ok, retire, f;
  // R-type funct to ALU operation; unknown funct is flagged for the trap
  always_comb begin
    r_ok = 1'b1;
    case (bus.funct)
      6'h20: r_ctl = ALU_ADD;
      6'h22: r_ctl = ALU_SUB;
      6'h24: r_ctl = ALU_AND;
      6'h25: r_ctl = ALU_OR;
      6'h2A: r_ctl = ALU_SLT;
      6'h00: r_ctl = ALU_SLL;
      6'h02: r_ctl = ALU_SRL;
      default: begin
        r_ctl = ALU_AND;
        r_ok = 1'b0;
      end
    endcase
  end
  // I-type opcode to ALU operation
  always_comb begin
    i_ctl = bus.op == 6'h08 ? ALU_ADD :
            bus.op == 6'h0A ? ALU_SLT :
            bus.op == 6'h0D ? ALU_OR : ALU_AND;
  end
  // next-state sequencing; memory phases hold until the access completes
  always_comb begin
    nxt = INIT;
    case (st)
      INIT:      nxt = FETCH;
      FETCH:     nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.op)
          6'h00:                      nxt = R_EXEC;
          6'h23, 6'h2B:               nxt = MEM_ADDR;
          6'h04, 6'h05:               nxt = BRANCH;
          6'h08, 6'h0A, 6'h0C, 6'h0D: nxt = I_EXEC;
          6'h02:                      nxt = JUMP;
          default:                    nxt = TRAP;
        endcase
      R_EXEC:    nxt = r_ok ? R_WB : TRAP;
      MEM_ADDR:  nxt = bus.op == 6'h2B ? MEM_WRITE : MEM_READ;
      MEM_READ:  nxt = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt = bus.mem_ready ? FETCH : MEM_WRITE;
      I_EXEC:    nxt = I_WB;
      R_WB, MEM_WB, I_WB, BRANCH, JUMP: nxt = FETCH;
      TRAP:      nxt = TRAP;
      default:   nxt = INIT;
    endcase
  end
  assign retire = st == R_WB || st == I_WB || st == MEM_WB || st == BRANCH || st == JUMP ||
                  (st == MEM_WRITE && bus.mem_ready);
  // state register and wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st <= INIT;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= cnt + N'(retire);
    end
  end
  assign f = st == FETCH;
  assign bus.state = st;
  assign bus.retired = cnt;
  assign bus.illegal = st == TRAP;
  assign bus.ir_we = f && bus.mem_ready;
  assign bus.pc_we = (f && bus.mem_ready) || st == JUMP ||
                     (st == BRANCH && (bus.zero ^ (bus.op == 6'h05)));
  assign bus.pc_src = st == BRANCH ? 2'b01 : st == JUMP ? 2'b10 : 2'b00;
  assign bus.mem_req = f || st == MEM_READ || st == MEM_WRITE;
  assign bus.mem_we = st == MEM_WRITE;
  assign bus.iord = st == MEM_READ || st == MEM_WRITE;
  assign bus.reg_we = st == R_WB || st == MEM_WB || st == I_WB;
  assign bus.reg_dst = st == R_WB;
  assign bus.mem_to_reg = st == MEM_WB;
  assign bus.alu_src_a = st == R_EXEC || st == MEM_ADDR || st == BRANCH || st == I_EXEC;
  assign bus.alu_src_b = f ? 2'b01 : st == DECODE ? 2'b11 :
                         (st == MEM_ADDR || st == I_EXEC) ? 2'b10 : 2'b00;
  assign bus.ext_zero = st == I_EXEC && (bus.op == 6'h0C || bus.op == 6'h0D);
  assign bus.alu_ctl = (f || st == DECODE || st == MEM_ADDR) ? ALU_ADD :
                       st == R_EXEC ? r_ctl :
                       st == I_EXEC ? i_ctl :
                       st == BRANCH ? ALU_SUB : ALU_AND;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized instruction streams checked against a per-instruction phase-list model
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic [17:0] w;
    logic wr, fe, zb, nzb, ret, term;
  } step_t;
  localparam logic [17:0] PCWE = 18'h20000, IRWE = 18'h04000, MREQ = 18'h02000, MWE = 18'h01000;
  localparam logic [17:0] IORD = 18'h00800, RWE = 18'h00400, RDST = 18'h00200, M2R = 18'h00100;
  localparam logic [17:0] SA = 18'h00080, EZ = 18'h00010, ILL = 18'h00001;
  localparam logic [17:0] PS01 = 18'h08000, PS10 = 18'h10000;
  localparam logic [17:0] SB01 = 18'h00020, SB10 = 18'h00040, SB11 = 18'h00060;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SLL = 3'b011;
  localparam logic [2:0] A_SRL = 3'b100, A_SUB = 3'b110, A_SLT = 3'b111;
  localparam logic [5:0] F_WR = 6'b100000, F_FE = 6'b010000, F_ZB = 6'b001000;
  localparam logic [5:0] F_NZB = 6'b000100, F_RET = 6'b000010, F_TERM = 6'b000001;
  logic clk = 1'b0, rstb = 1'b0;
  logic [5:0] op = 6'h0, funct = 6'h0;
  logic zero = 1'b0, mem_ready = 1'b0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl_if #(.N(32)) b32();
  mips_multicycle_ctrl_if #(.N(4)) b4();
  assign b32.op = op;
  assign b32.funct = funct;
  assign b32.zero = zero;
  assign b32.mem_ready = mem_ready;
  assign b4.op = op;
  assign b4.funct = funct;
  assign b4.zero = zero;
  assign b4.mem_ready = mem_ready;
  mips_multicycle_ctrl #(.N(32)) dut32 (.clk(clk), .rstb(rstb), .bus(b32));
  mips_multicycle_ctrl #(.N(4)) dut4 (.clk(clk), .rstb(rstb), .bus(b4));
  logic [17:0] w32, w4;
  assign w32 = {b32.pc_we, b32.pc_src, b32.ir_we, b32.mem_req, b32.mem_we, b32.iord, b32.reg_we,
                b32.reg_dst, b32.mem_to_reg, b32.alu_src_a, b32.alu_src_b, b32.ext_zero, b32.alu_ctl, b32.illegal};
  assign w4 = {b4.pc_we, b4.pc_src, b4.ir_we, b4.mem_req, b4.mem_we, b4.iord, b4.reg_we,
               b4.reg_dst, b4.mem_to_reg, b4.alu_src_a, b4.alu_src_b, b4.ext_zero, b4.alu_ctl, b4.illegal};
  step_t q[$];
  logic [11:0] force_q[$];
  int unsigned cnt = 0;
  int trapc = 0, lowcnt = 0, mode = 1, nchk = 0, nfail = 0;

  function automatic step_t st(input logic [17:0] w, input logic [5:0] f);
    return step_t'({w, f});
  endfunction

  function automatic logic [17:0] ctl(input logic [2:0] c);
    return {14'h0, c, 1'b0};
  endfunction

  function automatic logic [5:0] legal_op(input int i);
    case (i)
      0: return 6'h00; 1: return 6'h23; 2: return 6'h2B; 3: return 6'h04; 4: return 6'h05;
      5: return 6'h08; 6: return 6'h0A; 7: return 6'h0C; 8: return 6'h0D; default: return 6'h02;
    endcase
  endfunction

  function automatic logic [5:0] legal_fn(input int i);
    case (i)
      0: return 6'h20; 1: return 6'h22; 2: return 6'h24; 3: return 6'h25;
      4: return 6'h2A; 5: return 6'h00; default: return 6'h02;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole instruction expanded into the list of phases it must walk through.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] fn);
    logic [2:0] c;
    logic ok;
    q.push_back(st(MREQ | SB01 | ctl(A_ADD), F_WR | F_FE));
    q.push_back(st(SB11 | ctl(A_ADD), 6'h0));
    if (o == 6'h00) begin
      ok = 1'b1;
      case (fn)
        6'h20: c = A_ADD; 6'h22: c = A_SUB; 6'h24: c = A_AND; 6'h25: c = A_OR;
        6'h2A: c = A_SLT; 6'h00: c = A_SLL; 6'h02: c = A_SRL;
        default: begin c = A_AND; ok = 1'b0; end
      endcase
      q.push_back(st(SA | ctl(c), 6'h0));
      if (ok) q.push_back(st(RWE | RDST, F_RET));
      else q.push_back(st(ILL, F_TERM));
    end else if (o == 6'h23 || o == 6'h2B) begin
      q.push_back(st(SA | SB10 | ctl(A_ADD), 6'h0));
      if (o == 6'h23) begin
        q.push_back(st(MREQ | IORD, F_WR));
        q.push_back(st(RWE | M2R, F_RET));
      end else q.push_back(st(MREQ | MWE | IORD, F_WR | F_RET));
    end else if (o == 6'h04 || o == 6'h05) begin
      q.push_back(st(PS01 | SA | ctl(A_SUB), (o == 6'h04 ? F_ZB : F_NZB) | F_RET));
    end else if (o == 6'h08 || o == 6'h0A || o == 6'h0C || o == 6'h0D) begin
      c = o == 6'h08 ? A_ADD : o == 6'h0A ? A_SLT : o == 6'h0C ? A_AND : A_OR;
      q.push_back(st(SA | SB10 | ((o == 6'h0C || o == 6'h0D) ? EZ : 18'h0) | ctl(c), 6'h0));
      q.push_back(st(RWE, F_RET));
    end else if (o == 6'h02) begin
      q.push_back(st(PCWE | PS10, F_RET));
    end else q.push_back(st(ILL, F_TERM));
  endtask

  task automatic pick(output logic [5:0] o, output logic [5:0] fn);
    if (force_q.size() > 0) {o, fn} = force_q.pop_front();
    else begin
      o = ($urandom_range(0, 19) == 0) ? 6'($urandom) : legal_op(int'($urandom_range(0, 9)));
      fn = ($urandom_range(0, 19) == 0) ? 6'($urandom) : legal_fn(int'($urandom_range(0, 6)));
    end
  endtask

  // Model advance on each edge, then drive the next cycle's inputs.
  initial begin : mdl
    step_t s;
    logic [5:0] no, nf;
    logic newi;
    q.push_back(st(18'h0, 6'h0));
    forever begin
      @(posedge clk);
      newi = 1'b0;
      if (!rstb) begin
        q.delete();
        q.push_back(st(18'h0, 6'h0));
        cnt = 0;
        trapc = 0;
      end else begin
        s = q[0];
        if (s.term) trapc++;
        else if (!(s.wr && !mem_ready)) begin
          if (s.ret) cnt++;
          void'(q.pop_front());
          if (q.size() == 0) begin
            pick(no, nf);
            push_instr(no, nf);
            newi = 1'b1;
          end
        end
      end
      #1;
      if (newi) begin
        op = no;
        funct = nf;
      end
      zero = (mode != 0) ? 1'b1 : 1'($urandom);
      if (lowcnt > 0 && q[0].wr && !q[0].fe) begin
        mem_ready = 1'b0;
        lowcnt--;
      end else mem_ready = (mode != 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin : cmp
    step_t s;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        chk("rst_w32", 32'(w32), 32'h0);
        chk("rst_w4", 32'(w4), 32'h0);
        chk("rst_r32", b32.retired, 32'h0);
        chk("rst_r4", 32'(b4.retired), 32'h0);
      end else begin
        s = q[0];
        e = s.w;
        if (s.fe && mem_ready) e = e | PCWE | IRWE;
        if ((s.zb && zero) || (s.nzb && !zero)) e = e | PCWE;
        chk("ctl_w32", 32'(w32), 32'(e));
        chk("ctl_w4", 32'(w4), 32'(e));
        chk("retired32", b32.retired, cnt);
        chk("retired4", 32'(b4.retired), 32'(cnt[3:0]));
      end
    end
  end

  initial begin
    int c, k;
    force_q.push_back({6'h00, 6'h20});
    force_q.push_back({6'h23, 6'h00});
    force_q.push_back({6'h04, 6'h00});
    force_q.push_back({6'h05, 6'h00});
    force_q.push_back({6'h0D, 6'h00});
    force_q.push_back({6'h3F, 6'h20});
    lowcnt = 3;
    @(negedge clk);
    chk("reset_illegal", 32'(b32.illegal), 32'h0);
    chk("reset_mem_req", 32'(b32.mem_req), 32'h0);
    @(posedge clk);
    #2 rstb = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t1_rwb_reg_we", 32'(b32.reg_we), 32'h1);
    chk("t1_rwb_reg_dst", 32'(b32.reg_dst), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("t1_retired", b32.retired, 32'd1);
    c = 0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
      if (b32.mem_req && b32.iord) c++;
    end
    chk("t2_memread_cycles", 32'(c), 32'd4);
    chk("t2_mem_to_reg", 32'(b32.mem_to_reg), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("t2_retired", b32.retired, 32'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_beq_pc_we", 32'(b32.pc_we), 32'h1);
    chk("t3_beq_pc_src", 32'(b32.pc_src), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t3_bne_pc_we", 32'(b32.pc_we), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_retired", b32.retired, 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_ext_zero", 32'(b32.ext_zero), 32'h1);
    chk("t4_alu_src_b", 32'(b32.alu_src_b), 32'h2);
    chk("t4_alu_ctl", 32'(b32.alu_ctl), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("t4_iwb_reg_we", 32'(b32.reg_we), 32'h1);
    chk("t4_iwb_reg_dst", 32'(b32.reg_dst), 32'h0);
    repeat (3) @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("t5_illegal_sticky", 32'(b32.illegal), 32'h1);
      @(posedge clk);
    end
    chk("t5_retired_held", b32.retired, 32'd5);
    force_q.push_back({6'h00, 6'h3F});
    #2 rstb = 1'b0;
    @(negedge clk);
    chk("t5_rst_illegal", 32'(b32.illegal), 32'h0);
    @(posedge clk);
    #2 rstb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_rexec_no_trap_yet", 32'(b32.illegal), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_funct_trap", 32'(b32.illegal), 32'h1);
    repeat (15) force_q.push_back({6'h02, 6'h00});
    force_q.push_back({6'h2B, 6'h00});
    lowcnt = 5;
    @(posedge clk);
    #2 rstb = 1'b0;
    @(posedge clk);
    #2 rstb = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b32.mem_we && k < 200);
    chk("t6_reach_memwrite", 32'(k < 200), 32'h1);
    chk("t6_pre_r4", 32'(b4.retired), 32'd15);
    chk("t6_pre_r32", b32.retired, 32'd15);
    #2 rstb = 1'b0;
    #1;
    chk("t6_abort_mem_req", 32'(b4.mem_req), 32'h0);
    chk("t6_abort_mem_we", 32'(b4.mem_we), 32'h0);
    chk("t6_abort_r4", 32'(b4.retired), 32'h0);
    chk("t6_abort_r32", b32.retired, 32'h0);
    repeat (16) force_q.push_back({6'h02, 6'h00});
    @(posedge clk);
    lowcnt = 0;
    #2 rstb = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (b32.retired != 32'd16 && k < 200);
    chk("t6_wrap_reach", 32'(k < 200), 32'h1);
    chk("t6_wrap_r4", 32'(b4.retired), 32'h0);
    mode = 0;
    repeat (3000) begin
      @(posedge clk);
      if (trapc > 4 || $urandom_range(0, 299) == 0) begin
        #2 rstb = 1'b0;
        @(posedge clk);
        #2 rstb = 1'b1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
